// File: rtl/solver_scheduler.sv
// Frame scheduler that shares a pool of Mandelbrot solvers across every pixel
// of the screen. Pixels are swept in row-major order. Each pixel's cr/ci is
// derived incrementally from the previous pixel's value. Results are written
// back into the pixel memory through a write port gated by wr_ready.
//
// state | meaning
// IDLE  | waiting for start; all solvers free
// RUN   | sweeping pixels, dispatching one per cycle while a solver is free
// DRAIN | all pixels dispatched; collecting the remaining results
module solver_scheduler #(
  parameter int NUM_SOLVERS = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ADDR_W      = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [26:0]               cr_start,
  input  logic [26:0]               ci_start,
  input  logic [26:0]               d_re,
  input  logic [26:0]               d_im,
  input  logic [12:0]               max_iter,
  output logic [NUM_SOLVERS-1:0]    solver_reset,
  output logic [27*NUM_SOLVERS-1:0] solver_cr,
  output logic [27*NUM_SOLVERS-1:0] solver_ci,
  output logic [12:0]               solver_max_iter,
  input  logic [13*NUM_SOLVERS-1:0] solver_iter,
  input  logic [NUM_SOLVERS-1:0]    solver_done,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [12:0]               wr_data,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int XW   = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int PW   = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [26:0]            cr_base;
  logic [26:0]            d_re_q;
  logic [26:0]            d_im_q;
  logic [26:0]            cr_cur;
  logic [26:0]            ci_cur;
  logic [XW-1:0]          x;
  logic [ADDR_W-1:0]      addr;
  logic [NUM_SOLVERS-1:0] slot_busy;
  // Per-solver down-counter masking a done_reg left over from the previous pixel.
  logic [1:0]             guard [NUM_SOLVERS];
  logic [ADDR_W-1:0]      tag   [NUM_SOLVERS];
  logic [PW-1:0]          rr_ptr;

  logic                   disp_ok;
  logic [PW-1:0]          disp_idx;
  logic                   col_ok;
  logic [PW-1:0]          col_idx;
  logic                   col_fire;

  // Pick the lowest-index free solver as the dispatch target.
  always_comb begin
    disp_ok  = 1'b0;
    disp_idx = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        disp_ok  = 1'b1;
        disp_idx = PW'(i);
      end
    end
  end

  // Round-robin search, starting at rr_ptr, for a busy solver that is past its guard and done.
  always_comb begin
    logic [PW-1:0] cand;
    col_ok  = 1'b0;
    col_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_SOLVERS);
      if (!col_ok && slot_busy[cand] && (guard[cand] == 2'd0) && solver_done[cand]) begin
        col_ok  = 1'b1;
        col_idx = cand;
      end
    end
  end

  assign col_fire = col_ok && wr_ready;

  // Sequencer: frame state, pixel sweep, dispatch and collect, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cr_base         <= '0;
      d_re_q          <= '0;
      d_im_q          <= '0;
      cr_cur          <= '0;
      ci_cur          <= '0;
      x               <= '0;
      addr            <= '0;
      slot_busy       <= '0;
      rr_ptr          <= '0;
      solver_reset    <= '1;
      solver_cr       <= '0;
      solver_ci       <= '0;
      solver_max_iter <= '0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        guard[i] <= '0;
        tag[i]   <= '0;
      end
    end else begin
      solver_reset <= '0;
      wr_en        <= 1'b0;
      frame_done   <= 1'b0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        if (guard[i] != 2'd0) guard[i] <= guard[i] - 2'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cr_base         <= cr_start;
            d_re_q          <= d_re;
            d_im_q          <= d_im;
            solver_max_iter <= max_iter;
            cr_cur          <= cr_start;
            ci_cur          <= ci_start;
            x               <= '0;
            addr            <= '0;
            busy            <= 1'b1;
            state           <= RUN;
          end
        end
        RUN: begin
          if (disp_ok) begin
            solver_cr[int'(disp_idx)*27 +: 27] <= cr_cur;
            solver_ci[int'(disp_idx)*27 +: 27] <= ci_cur;
            solver_reset[disp_idx]             <= 1'b1;
            slot_busy[disp_idx]                <= 1'b1;
            guard[disp_idx]                    <= 2'd2;
            tag[disp_idx]                      <= addr;
            addr                               <= addr + 1'b1;
            if (x == XW'(SCREEN_W - 1)) begin
              x      <= '0;
              cr_cur <= cr_base;
              ci_cur <= ci_cur - d_im_q;
            end else begin
              x      <= x + 1'b1;
              cr_cur <= cr_cur + d_re_q;
            end
            if (addr == ADDR_W'(NPIX - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (slot_busy == '0) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The collect target is always busy and the dispatch target always free, so they never collide.
      if (col_fire) begin
        wr_en              <= 1'b1;
        wr_addr            <= tag[col_idx];
        wr_data            <= solver_iter[int'(col_idx)*13 +: 13];
        slot_busy[col_idx] <= 1'b0;
        rr_ptr             <= PW'((int'(col_idx) + 1) % NUM_SOLVERS);
      end
    end
  end

endmodule
